// File: rtl/image_streamer_pkg.sv
// Shared definitions for the image streamer: frame geometry, scan length,
// controller state encoding and the centering-offset helper.
package image_streamer_pkg;

    localparam int IMG_DIM   = 32;
    localparam int PIX_COUNT = 1024;
    localparam int SCAN_LEN  = 32;
    localparam int COORD_W   = 5;
    localparam int OFF_W     = 7;
    localparam int CNT_W     = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VS = 3'd1,
        ST_SNAP    = 3'd2,
        ST_SCAN    = 3'd3,
        ST_STREAM  = 3'd4
    } state_e;

    // Shift needed to move the bounding box [lo, hi] to the frame centre.
    // The arithmetic shift rounds toward minus infinity for negative sums.
    function automatic logic signed [OFF_W-1:0] center_offset(
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        logic signed [OFF_W-1:0] diff;
        diff = 7'sd31 - $signed({2'b00, lo}) - $signed({2'b00, hi});
        return diff >>> 1;
    endfunction

endpackage

// File: rtl/image_streamer_bbox_scan.sv
// Bounding-box search for the image streamer. One snapshot column arrives per
// cycle; the first and last inked columns give xmin/xmax, and every column is
// OR-ed into a row mask whose lowest/highest set bits give ymin/ymax.
module bbox_scan
    import image_streamer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    scan_en,
    input  logic [COORD_W-1:0]      col_idx,
    input  logic [IMG_DIM-1:0]      col_word,
    output logic signed [OFF_W-1:0] dx,
    output logic signed [OFF_W-1:0] dy,
    output logic                    empty
);

    logic [COORD_W-1:0] xmin_q, xmin_d;
    logic [COORD_W-1:0] xmax_q, xmax_d;
    logic               found_q, found_d;
    logic [IMG_DIM-1:0] rowmask_q, rowmask_d;
    logic               col_ink_s;
    logic [COORD_W-1:0] ymin_s;
    logic [COORD_W-1:0] ymax_s;

    // Next-state of the column search; columns arrive in ascending order so
    // the first inked column is xmin and the latest inked column is xmax.
    always_comb begin
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        found_d   = found_q;
        rowmask_d = rowmask_q;
        col_ink_s = |col_word;
        if (clear) begin
            xmin_d    = 5'd0;
            xmax_d    = 5'd0;
            found_d   = 1'b0;
            rowmask_d = 32'd0;
        end else if (scan_en) begin
            rowmask_d = rowmask_q | col_word;
            if (col_ink_s) begin
                xmax_d  = col_idx;
                found_d = 1'b1;
                if (!found_q) begin
                    xmin_d = col_idx;
                end else begin
                    xmin_d = xmin_q;
                end
            end else begin
                xmax_d = xmax_q;
            end
        end else begin
            rowmask_d = rowmask_q;
        end
    end

    // Search registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin_q    <= 5'd0;
            xmax_q    <= 5'd0;
            found_q   <= 1'b0;
            rowmask_q <= 32'd0;
        end else begin
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            found_q   <= found_d;
            rowmask_q <= rowmask_d;
        end
    end

    // Row priority encoders: lowest and highest set bit of the row mask
    always_comb begin
        ymin_s = 5'd0;
        ymax_s = 5'd0;
        for (int i = IMG_DIM - 1; i >= 0; i--) begin
            ymin_s = rowmask_q[i] ? 5'(i) : ymin_s;
        end
        for (int i = 0; i < IMG_DIM; i++) begin
            ymax_s = rowmask_q[i] ? 5'(i) : ymax_s;
        end
    end

    // Empty looks at the mask including the column being absorbed this cycle,
    // so it is already final during the last scan cycle.
    assign empty = (rowmask_d == 32'd0);
    assign dx    = center_offset(xmin_q, xmax_q);
    assign dy    = center_offset(ymin_s, ymax_s);

endmodule

// File: rtl/image_streamer.sv
// Image streamer: on request, waits for the next VGA vertical-sync falling
// edge, snapshots the 32x32 drawing, finds its bounding box, and streams a
// centred 1024-pixel frame row-major over a valid/ready handshake.
module image_streamer
    import image_streamer_pkg::*;
#(
    parameter logic [7:0] P_ON_VALUE  = 8'hFF,
    parameter logic [7:0] P_OFF_VALUE = 8'h00
)(
    input  logic          clkVga,
    input  logic          iRstN,
    input  logic [1023:0] iImage,
    input  logic          iVs,
    input  logic          iStart,
    output logic [7:0]    oPixel,
    output logic          oValid,
    input  logic          iReady,
    output logic          oLast,
    output logic          oBusy,
    output logic          oEmpty
);

    logic [1:0]              rst_sync_q;
    logic                    rst_n_s;

    state_e                  state_q, state_d;
    logic                    vs_q, vs_d;
    logic [PIX_COUNT-1:0]    snapshot_q, snapshot_d;
    logic [COORD_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [CNT_W-1:0]        pix_cnt_q, pix_cnt_d;
    logic [7:0]              pixel_q, pixel_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    empty_q, empty_d;

    logic                    vs_fall_s;
    logic                    xfer_s;
    logic                    load_s;
    logic                    scan_clear_s;
    logic                    scan_en_s;
    logic                    scan_empty_s;
    logic [IMG_DIM-1:0]      col_word_s;
    logic signed [OFF_W-1:0] dx_s;
    logic signed [OFF_W-1:0] dy_s;
    logic [COORD_W-1:0]      x_s;
    logic [COORD_W-1:0]      y_s;
    logic signed [OFF_W-1:0] sx_s;
    logic signed [OFF_W-1:0] sy_s;
    logic [9:0]              bit_idx_s;
    logic                    src_in_s;
    logic [7:0]              src_pix_s;

    // Reset asserts immediately but is released two clkVga edges later
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_q[1];

    assign col_word_s = snapshot_q[{scan_cnt_q, 5'd0} +: IMG_DIM];

    bbox_scan u_bbox_scan (
        .clk      (clkVga),
        .rst_n    (rst_n_s),
        .clear    (scan_clear_s),
        .scan_en  (scan_en_s),
        .col_idx  (scan_cnt_q),
        .col_word (col_word_s),
        .dx       (dx_s),
        .dy       (dy_s),
        .empty    (scan_empty_s)
    );

    // Source lookup for the next pixel to issue: shift back by the centering
    // offset and blank anything that falls outside the 32x32 snapshot.
    always_comb begin
        x_s       = pix_cnt_q[4:0];
        y_s       = pix_cnt_q[9:5];
        sx_s      = $signed({2'b00, x_s}) - dx_s;
        sy_s      = $signed({2'b00, y_s}) - dy_s;
        src_in_s  = (sx_s[6:5] == 2'b00) && (sy_s[6:5] == 2'b00);
        bit_idx_s = {sx_s[4:0], sy_s[4:0]};
        if (src_in_s && snapshot_q[bit_idx_s]) begin
            src_pix_s = P_ON_VALUE;
        end else begin
            src_pix_s = P_OFF_VALUE;
        end
    end

    // Controller next state: capture sequencing, scan counting and the
    // output skid-free register that reloads whenever it is empty or drained.
    always_comb begin
        state_d      = state_q;
        vs_d         = iVs;
        snapshot_d   = snapshot_q;
        scan_cnt_d   = scan_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        pixel_d      = pixel_q;
        valid_d      = valid_q;
        last_d       = last_q;
        empty_d      = 1'b0;
        scan_clear_s = 1'b0;
        scan_en_s    = 1'b0;
        vs_fall_s    = vs_q & ~iVs;
        xfer_s       = valid_q & iReady;
        load_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_WAIT_VS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                if (vs_fall_s) begin
                    state_d = ST_SNAP;
                end else begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_SNAP: begin
                snapshot_d   = iImage;
                scan_clear_s = 1'b1;
                scan_cnt_d   = 5'd0;
                state_d      = ST_SCAN;
            end
            ST_SCAN: begin
                scan_en_s  = 1'b1;
                scan_cnt_d = scan_cnt_q + 5'd1;
                if (scan_cnt_q == 5'(SCAN_LEN - 1)) begin
                    if (scan_empty_s) begin
                        empty_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        pix_cnt_d = 11'd0;
                        valid_d   = 1'b0;
                        last_d    = 1'b0;
                        state_d   = ST_STREAM;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_STREAM: begin
                load_s = (pix_cnt_q != 11'(PIX_COUNT)) && (!valid_q || iReady);
                if (load_s) begin
                    pixel_d   = src_pix_s;
                    valid_d   = 1'b1;
                    last_d    = (pix_cnt_q == 11'(PIX_COUNT - 1));
                    pix_cnt_d = pix_cnt_q + 11'd1;
                end else if (xfer_s) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Controller and output registers
    always_ff @(posedge clkVga or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q    <= ST_IDLE;
            vs_q       <= 1'b0;
            snapshot_q <= '0;
            scan_cnt_q <= 5'd0;
            pix_cnt_q  <= 11'd0;
            pixel_q    <= 8'd0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            empty_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_d;
            snapshot_q <= snapshot_d;
            scan_cnt_q <= scan_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            pixel_q    <= pixel_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            empty_q    <= empty_d;
        end
    end

    assign oPixel = pixel_q;
    assign oValid = valid_q;
    assign oLast  = last_q;
    assign oBusy  = busy_q;
    assign oEmpty = empty_q;

endmodule

// File: doc/image_streamer.md
IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 SHALL have parameter P_ON_VALUE, default 8'hFF: oPixel value for an inked pixel.
REQ-002 SHALL have parameter P_OFF_VALUE, default 8'h00: oPixel value for a blank pixel.
REQ-003 SHALL have port clkVga  input  1  clock, the 40 MHz VGA clock.
REQ-004 SHALL have port iRstN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iImage  input  1024  drawing bitmap; bit index = x*32 + y, with x, y in 0..31.
REQ-006 SHALL have port iVs  input  1  VGA vertical sync, active-low, synchronous to clkVga.
REQ-007 SHALL have port iStart  input  1  single-cycle request to capture and stream one frame.
REQ-008 SHALL have port oPixel  output  8  pixel data.
REQ-009 SHALL have port oValid  output  1  oPixel valid.
REQ-010 SHALL have port iReady  input  1  downstream (DNN) accepts the pixel.
REQ-011 SHALL have port oLast  output  1  high with the 1024th pixel.
REQ-012 SHALL have port oBusy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port oEmpty  output  1  one-cycle pulse when the captured image contains no ink.

Function
REQ-014 SHALL implement states IDLE, WAIT_VS, SNAP, SCAN, STREAM.
- IDLE -> WAIT_VS on iStart.
- WAIT_VS -> SNAP on the first cycle iVs is sampled 0 after having been sampled 1 (falling edge, registered iVs).
- SNAP -> SCAN after 1 cycle.
- SCAN -> STREAM after exactly 32 cycles.
- STREAM -> IDLE on the transfer with oLast high.
REQ-015 SHALL ignore iStart in any state other than IDLE.
REQ-016 SNAP SHALL latch iImage into an internal 1024-bit snapshot; later iImage changes SHALL NOT affect the streamed frame.
REQ-017 SCAN SHALL process one column x = c per cycle, c = 0..31.
- Column ink = OR of snapshot bits c*32 .. c*32+31.
- xmin/xmax updated with c when column ink is present.
- 32-bit rowMask |= column word.
REQ-018 At SCAN end, ymin/ymax SHALL be the lowest and highest set bits of rowMask.
REQ-019 Centering offsets SHALL be dx = (31 - xmin - xmax) >>> 1 and dy = (31 - ymin - ymax) >>> 1, 7-bit signed, arithmetic shift.
REQ-020 If rowMask == 0 at SCAN end, the block SHALL pulse oEmpty for 1 cycle, skip STREAM, and return to IDLE.
REQ-021 STREAM SHALL emit 1024 pixels row-major: y outer 0..31, x inner 0..31.
- Source coordinate = (x - dx, y - dy), computed in 7-bit signed.
- A source outside 0..31 SHALL emit P_OFF_VALUE.
- Otherwise the block SHALL emit P_ON_VALUE when the snapshot bit is set, else P_OFF_VALUE.
REQ-022 Handshake: a transfer occurs when oValid and iReady are both high.
- oPixel and oLast SHALL stay stable while oValid is high and iReady is low.
- oValid SHALL NOT drop before the transfer occurs.
REQ-023 The pixel path SHALL be registered.
- First oValid SHALL occur 1 cycle after STREAM entry.
- With iReady held high, the block SHALL deliver one pixel per cycle with no bubbles.
REQ-024 oLast SHALL be high only on pixel 1023 (x = 31, y = 31).
REQ-025 oValid SHALL be 0 in the cycle after the oLast transfer.
REQ-026 Latency: first oValid SHALL occur 34 cycles after the iVs falling-edge detection (1 SNAP + 32 SCAN + 1 register).

Reset
REQ-027 On iRstN low the block SHALL asynchronously enter IDLE and clear all of the following:
- oPixel = 0, oValid = 0, oLast = 0, oBusy = 0, oEmpty = 0.
- Snapshot, counters, bounding box and rowMask.
REQ-028 A reset mid-STREAM SHALL abort the frame with no further oValid.
- The next iStart after reset SHALL start a complete 1024-pixel frame.
REQ-029 Reset release SHALL be synchronised to clkVga (two-stage release).

Structure
REQ-030 A shared package SHALL hold the following:
- State encoding.
- Image dimension constant IMG_DIM = 32 and pixel count 1024.
- Scan length 32.
REQ-031 Bounding-box centering SHALL be a sub-module bbox_scan: column-serial min/max search plus row priority encoders, outputting dx, dy and empty.
REQ-032 The streaming FSM, counters and handshake SHALL remain in image_streamer.

Verification
REQ-033 Single ink pixel at x=0, y=0, iStart, iReady=1 -> dx = dy = 15; exactly one P_ON_VALUE pixel, at stream index 15*32 + 15 = 495; oLast on index 1023.
REQ-034 Already-centred 2x2 block at x,y = 15..16 -> dx = dy = 0; output identical to the snapshot in row-major order.
REQ-035 Blank image, iStart -> oEmpty one-cycle pulse 33 cycles after the iVs edge; oValid never asserted; back to IDLE.
REQ-036 iReady randomly toggled at 50% -> exactly 1024 transfers; oPixel stable during every stall; oLast only on the final transfer.
REQ-037 iImage changed during STREAM and iStart re-pulsed while busy -> output matches the SNAP-time snapshot; the second iStart is ignored.
REQ-038 iRstN asserted at pixel 500 -> outputs 0 asynchronously; a fresh iStart yields a full, correct 1024-pixel frame.
